mfm_sector_parser: RTL and testbench

- Consumes the decoded byte stream and address-mark indications from the serial MFM sync decoder.
- Frames ID fields and data fields, and extracts C/H/R/N from each ID field.
- Checks CRC-16/CCITT on both field types.
- Streams sector payload bytes to the downstream sector buffer with per-byte index and end-of-field status.

---
 rtl/mfm_sector_parser.sv | 206 ++++++++++++++++++++
 tb/tb_mfm_sector_parser.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_sector_parser.sv
// MFM sector parser: frames ID and data fields from the sync decoder byte
// stream, extracts C/H/R/N, checks CRC-16/CCITT and streams payload bytes.
module mfm_sector_parser #(
  parameter int unsigned MAX_SIZE_CODE = 3,
  parameter logic [15:0] CRC_PRESET    = 16'hCDB4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        am_detected,
  input  logic [1:0]  am_type,
  output logic        id_valid,
  output logic [7:0]  id_cyl,
  output logic [7:0]  id_head,
  output logic [7:0]  id_sector,
  output logic [7:0]  id_size,
  output logic        id_crc_ok,
  output logic [7:0]  data_byte,
  output logic        data_byte_valid,
  output logic [13:0] data_index,
  output logic        data_done,
  output logic        data_crc_ok,
  output logic        data_deleted,
  output logic        orphan_dam,
  output logic        field_abort
);

  typedef enum logic [1:0] {IDLE, ID_FIELD, DATA_FIELD} state_t;

  localparam logic [7:0] MAX_N = 8'(MAX_SIZE_CODE);

  function automatic logic [15:0] crc_step(input logic [15:0] crc_cur, input logic [7:0] data);
    logic [15:0] c;
    c = crc_cur ^ {data, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

  state_t      state, next_state;
  logic [14:0] count, next_count;
  logic [15:0] crc, next_crc;
  logic        id_good, next_id_good;
  logic [7:0]  fld_cyl, fld_head, fld_sector, fld_size;
  logic [7:0]  next_fld_cyl, next_fld_head, next_fld_sector, next_fld_size;
  logic        next_id_valid, next_id_crc_ok;
  logic [7:0]  next_id_cyl, next_id_head, next_id_sector, next_id_size;
  logic [7:0]  next_data_byte;
  logic        next_data_byte_valid, next_data_done, next_data_crc_ok, next_data_deleted;
  logic [13:0] next_data_index;
  logic        next_orphan_dam, next_field_abort;
  logic [15:0] crc_byte, crc_am;
  logic [2:0]  size_eff;
  logic [14:0] len;

  // ID bytes collect in fld_* and are published to id_* only when the field
  // completes, so id_* hold their last completed value across partial fields.
  always_comb begin
    next_state           = state;
    next_count           = count;
    next_crc             = crc;
    next_id_good         = id_good;
    next_fld_cyl         = fld_cyl;
    next_fld_head        = fld_head;
    next_fld_sector      = fld_sector;
    next_fld_size        = fld_size;
    next_id_valid        = 1'b0;
    next_id_crc_ok       = id_crc_ok;
    next_id_cyl          = id_cyl;
    next_id_head         = id_head;
    next_id_sector       = id_sector;
    next_id_size         = id_size;
    next_data_byte       = data_byte;
    next_data_byte_valid = 1'b0;
    next_data_index      = data_index;
    next_data_done       = 1'b0;
    next_data_crc_ok     = data_crc_ok;
    next_data_deleted    = data_deleted;
    next_orphan_dam      = 1'b0;
    next_field_abort     = 1'b0;

    crc_byte = crc_step(crc, byte_in);
    crc_am   = crc_step(CRC_PRESET, byte_in);
    size_eff = (id_size > MAX_N) ? MAX_N[2:0] : id_size[2:0];
    len      = 15'd128 << size_eff;

    if (!enable) begin
      if (state != IDLE) next_field_abort = 1'b1;
      next_state   = IDLE;
      next_id_good = 1'b0;
    end else if (byte_valid) begin
      if (am_detected) begin
        if (state != IDLE) next_field_abort = 1'b1;
        next_state = IDLE;
        next_crc   = crc_am;
        next_count = '0;
        if (am_type == 2'b01) begin
          next_state   = ID_FIELD;
          next_id_good = 1'b0;
        end else if (am_type[1]) begin
          if (id_good) begin
            next_state        = DATA_FIELD;
            next_data_deleted = am_type[0];
            next_id_good      = 1'b0;
          end else begin
            next_orphan_dam = 1'b1;
          end
        end
      end else begin
        unique case (state)
          ID_FIELD: begin
            next_crc   = crc_byte;
            next_count = count + 15'd1;
            unique case (count)
              15'd0: next_fld_cyl    = byte_in;
              15'd1: next_fld_head   = byte_in;
              15'd2: next_fld_sector = byte_in;
              15'd3: next_fld_size   = byte_in;
              15'd5: begin
                next_id_valid  = 1'b1;
                next_id_crc_ok = (crc_byte == 16'h0000);
                next_id_good   = (crc_byte == 16'h0000);
                next_id_cyl    = fld_cyl;
                next_id_head   = fld_head;
                next_id_sector = fld_sector;
                next_id_size   = fld_size;
                next_state     = IDLE;
              end
              default: ;
            endcase
          end
          DATA_FIELD: begin
            next_crc   = crc_byte;
            next_count = count + 15'd1;
            if (count < len) begin
              next_data_byte_valid = 1'b1;
              next_data_byte       = byte_in;
              next_data_index      = count[13:0];
            end
            if (count == len + 15'd1) begin
              next_data_done   = 1'b1;
              next_data_crc_ok = (crc_byte == 16'h0000);
              next_state       = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      crc             <= '1;
      id_good         <= 1'b0;
      fld_cyl         <= '0;
      fld_head        <= '0;
      fld_sector      <= '0;
      fld_size        <= '0;
      id_valid        <= 1'b0;
      id_crc_ok       <= 1'b0;
      id_cyl          <= '0;
      id_head         <= '0;
      id_sector       <= '0;
      id_size         <= '0;
      data_byte       <= '0;
      data_byte_valid <= 1'b0;
      data_index      <= '0;
      data_done       <= 1'b0;
      data_crc_ok     <= 1'b0;
      data_deleted    <= 1'b0;
      orphan_dam      <= 1'b0;
      field_abort     <= 1'b0;
    end else begin
      state           <= next_state;
      count           <= next_count;
      crc             <= next_crc;
      id_good         <= next_id_good;
      fld_cyl         <= next_fld_cyl;
      fld_head        <= next_fld_head;
      fld_sector      <= next_fld_sector;
      fld_size        <= next_fld_size;
      id_valid        <= next_id_valid;
      id_crc_ok       <= next_id_crc_ok;
      id_cyl          <= next_id_cyl;
      id_head         <= next_id_head;
      id_sector       <= next_id_sector;
      id_size         <= next_id_size;
      data_byte       <= next_data_byte;
      data_byte_valid <= next_data_byte_valid;
      data_index      <= next_data_index;
      data_done       <= next_data_done;
      data_crc_ok     <= next_data_crc_ok;
      data_deleted    <= next_data_deleted;
      orphan_dam      <= next_orphan_dam;
      field_abort     <= next_field_abort;
    end
  end

endmodule

// File: tb/tb_mfm_sector_parser.sv
// Self-checking bench for mfm_sector_parser: directed field sequences with
// random payloads, gaps and garbage, checked against a field-level model.
module tb_mfm_sector_parser;

  logic        clk = 1'b0;
  logic        reset, enable, byte_valid, am_detected;
  logic [7:0]  byte_in;
  logic [1:0]  am_type;
  logic        id_valid, id_crc_ok, data_byte_valid, data_done, data_crc_ok;
  logic        data_deleted, orphan_dam, field_abort;
  logic [7:0]  id_cyl, id_head, id_sector, id_size, data_byte;
  logic [13:0] data_index;

  always #5 clk = ~clk;

  mfm_sector_parser #(.MAX_SIZE_CODE(3), .CRC_PRESET(16'hCDB4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .byte_in(byte_in),
    .byte_valid(byte_valid), .am_detected(am_detected), .am_type(am_type),
    .id_valid(id_valid), .id_cyl(id_cyl), .id_head(id_head),
    .id_sector(id_sector), .id_size(id_size), .id_crc_ok(id_crc_ok),
    .data_byte(data_byte), .data_byte_valid(data_byte_valid),
    .data_index(data_index), .data_done(data_done), .data_crc_ok(data_crc_ok),
    .data_deleted(data_deleted), .orphan_dam(orphan_dam), .field_abort(field_abort)
  );

  typedef logic [7:0] bq_t[$];
  typedef int iq_t[$];
  typedef struct { int st; logic [7:0] c, h, r, n; logic ok; } id_ev_t;
  typedef struct { int st; logic [7:0] b; logic [13:0] idx; logic del; } db_ev_t;
  typedef struct { int st; logic ok; logic del; } dn_ev_t;

  id_ev_t id_q[$];
  db_ev_t db_q[$];
  dn_ev_t dn_q[$];
  int     orph_q[$];
  int     abort_q[$];
  int     st = 0;
  int     total = 0;
  int     passed = 0;
  int     failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bitwise CRC over a whole byte sequence, starting from FFFF.
  function automatic logic [15:0] crc_ref(input bq_t q);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 0; i < q.size(); i++)
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ q[i][k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    return c;
  endfunction

  function automatic bq_t with_crc(input logic [7:0] amb, input bq_t body, input logic bad);
    bq_t q, r;
    logic [15:0] c;
    q = {8'hA1, 8'hA1, 8'hA1, amb};
    foreach (body[i]) q.push_back(body[i]);
    c = crc_ref(q);
    if (bad) c = c ^ (16'h0001 << $urandom_range(0, 15));
    r = body;
    r.push_back(c[15:8]);
    r.push_back(c[7:0]);
    return r;
  endfunction

  function automatic bq_t id_body(input logic [7:0] c, h, r, n, input logic bad);
    bq_t b;
    b = {c, h, r, n};
    return with_crc(8'hFE, b, bad);
  endfunction

  function automatic bq_t rand_payload(input int len);
    bq_t p;
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  task automatic clear_logs();
    id_q.delete(); db_q.delete(); dn_q.delete(); orph_q.delete(); abort_q.delete();
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic am, input logic [1:0] t);
    byte_valid = v; byte_in = b; am_detected = am; am_type = t;
    @(posedge clk); #1;
    st++;
    if (id_valid) id_q.push_back('{st, id_cyl, id_head, id_sector, id_size, id_crc_ok});
    if (data_byte_valid) db_q.push_back('{st, data_byte, data_index, data_deleted});
    if (data_done) dn_q.push_back('{st, data_crc_ok, data_deleted});
    if (orphan_dam) orph_q.push_back(st);
    if (field_abort) abort_q.push_back(st);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'($urandom), 1'($urandom), 2'($urandom));
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
  endtask

  // sts[0] is the AM step, sts[i+1] the step of body[i].
  task automatic send_field(input logic [1:0] t, input logic [7:0] amb, input bq_t body, output iq_t sts);
    sts = {};
    step(1'b1, amb, 1'b1, t);
    sts.push_back(st);
    gap();
    foreach (body[i]) begin
      step(1'b1, body[i], 1'b0, 2'($urandom));
      sts.push_back(st);
      gap();
    end
  endtask

  task automatic check_id(input string tag, input int exp_st, input logic [7:0] c, h, r, n, input logic ok);
    check({tag, "_idcnt"}, 64'(id_q.size()), 64'd1);
    if (id_q.size() > 0) begin
      check({tag, "_idstep"}, 64'(id_q[0].st), 64'(exp_st));
      check({tag, "_chrn"}, {32'h0, id_q[0].c, id_q[0].h, id_q[0].r, id_q[0].n}, {32'h0, c, h, r, n});
      check({tag, "_idok"}, 64'(id_q[0].ok), 64'(ok));
    end
  endtask

  task automatic check_data(input string tag, input bq_t pay, input iq_t sts, input logic del,
                            input int exp_done, input logic ok);
    int errs;
    check({tag, "_nbytes"}, 64'(db_q.size()), 64'(pay.size()));
    errs = 0;
    for (int i = 0; i < db_q.size() && i < pay.size(); i++)
      if (db_q[i].b !== pay[i] || db_q[i].idx !== 14'(i) || db_q[i].del !== del || db_q[i].st != sts[i + 1])
        errs++;
    check({tag, "_byteerrs"}, 64'(errs), 64'd0);
    check({tag, "_donecnt"}, 64'(dn_q.size()), 64'(exp_done));
    if (exp_done > 0 && dn_q.size() > 0) begin
      check({tag, "_donestep"}, 64'(dn_q[0].st), 64'(sts[pay.size() + 2]));
      check({tag, "_doneok"}, {dn_q[0].ok, dn_q[0].del}, {ok, del});
    end
  endtask

  function automatic int plen(input logic [7:0] n);
    return 128 << ((n > 8'd3) ? 3 : int'(n));
  endfunction

  initial begin
    bq_t body, pay, empty;
    iq_t sts, sts2;
    logic [7:0] c, h, r, n;
    logic bad, ddam;
    int abort_st;

    empty = {};
    reset = 1'b1; enable = 1'b1;
    byte_valid = 1'b0; byte_in = '0; am_detected = 1'b0; am_type = '0;
    idle(3);
    check("reset_outputs",
          {2'b0, id_valid, id_cyl, id_head, id_sector, id_size, id_crc_ok, data_byte,
           data_byte_valid, data_index, data_done, data_crc_ok, data_deleted, orphan_dam, field_abort},
          64'd0);
    reset = 1'b0;
    idle(2);

    // Good ID field, literal bytes.
    clear_logs();
    send_field(2'b01, 8'hFE, {8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6F}, sts);
    idle(2);
    check_id("good_id", sts[6], 8'h00, 8'h00, 8'h01, 8'h02, 1'b1);

    // Bad ID CRC then DAM: orphan, no data.
    clear_logs();
    send_field(2'b01, 8'hFE, {8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6E}, sts);
    idle(1);
    check_id("bad_id", sts[6], 8'h00, 8'h00, 8'h01, 8'h02, 1'b0);
    send_field(2'b10, 8'hFB, rand_payload(8), sts);
    idle(2);
    check("bad_id_orphan", {32'(orph_q.size()), 32'(orph_q.size() > 0 ? orph_q[0] : -1)}, {32'd1, 32'(sts[0])});
    check("bad_id_nodata", 64'(db_q.size() + dn_q.size()), 64'd0);

    // Good 512-byte field; a type-00 AM in between must not disturb id_good.
    clear_logs();
    send_field(2'b01, 8'hFE, {8'h00, 8'h00, 8'h01, 8'h02, 8'hCA, 8'h6F}, sts);
    send_field(2'b00, 8'hA1, empty, sts);
    pay = {};
    for (int i = 0; i < 512; i++) pay.push_back(8'(i));
    clear_logs();
    send_field(2'b10, 8'hFB, with_crc(8'hFB, pay, 1'b0), sts);
    idle(2);
    check_data("d512", pay, sts, 1'b0, 1, 1'b1);
    check("d512_noside", 64'(orph_q.size() + abort_q.size() + id_q.size()), 64'd0);

    // Deleted field with N=05, clamped to 1024 bytes.
    clear_logs();
    c = 8'($urandom); h = 8'($urandom); r = 8'($urandom);
    send_field(2'b01, 8'hFE, id_body(c, h, r, 8'h05, 1'b0), sts);
    check_id("n5_id", sts[6], c, h, r, 8'h05, 1'b1);
    check("n5_idsize", 64'(id_size), 64'h05);
    clear_logs();
    pay = rand_payload(1024);
    send_field(2'b11, 8'hF8, with_crc(8'hF8, pay, 1'b0), sts);
    idle(2);
    check_data("ddam", pay, sts, 1'b1, 1, 1'b1);

    // Random fields, random sizes and CRC corruption.
    for (int k = 0; k < 4; k++) begin
      clear_logs();
      c = 8'($urandom); h = 8'($urandom); r = 8'($urandom);
      n = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 2));
      send_field(2'b01, 8'hFE, id_body(c, h, r, n, 1'b0), sts);
      check_id($sformatf("rnd%0d_id", k), sts[6], c, h, r, n, 1'b1);
      clear_logs();
      bad  = 1'($urandom);
      ddam = 1'($urandom);
      pay  = rand_payload(plen(n));
      send_field({1'b1, ddam}, ddam ? 8'hF8 : 8'hFB, with_crc(ddam ? 8'hF8 : 8'hFB, pay, bad), sts);
      idle(1);
      check_data($sformatf("rnd%0d_data", k), pay, sts, ddam, 1, !bad);
    end

    // Abort data field with IDAM after 100 bytes.
    c = 8'h12; h = 8'h01; r = 8'h07; n = 8'h02;
    send_field(2'b01, 8'hFE, id_body(8'h22, 8'h00, 8'h03, 8'h02, 1'b0), sts);
    clear_logs();
    pay = rand_payload(100);
    send_field(2'b10, 8'hFB, pay, sts);
    send_field(2'b01, 8'hFE, id_body(c, h, r, n, 1'b0), sts2);
    idle(2);
    check("abort_pulse", {32'(abort_q.size()), 32'(abort_q.size() > 0 ? abort_q[0] : -1)}, {32'd1, 32'(sts2[0])});
    check_data("abort_data", pay, sts, 1'b0, 0, 1'b0);
    check_id("abort_newid", sts2[6], c, h, r, n, 1'b1);

    // DAM inside a data field: abort and orphan together.
    clear_logs();
    send_field(2'b10, 8'hFB, rand_payload(30), sts);
    step(1'b1, 8'hFB, 1'b1, 2'b10);
    abort_st = st;
    idle(2);
    check("dam_in_data", {32'(abort_q.size()), 32'(orph_q.size())}, {32'd1, 32'd1});
    if (abort_q.size() > 0 && orph_q.size() > 0)
      check("dam_in_data_step", {32'(abort_q[0]), 32'(orph_q[0])}, {32'(abort_st), 32'(abort_st)});
    check("dam_in_data_done", 64'(dn_q.size()), 64'd0);

    // Enable low mid-ID: one abort, no id_valid.
    clear_logs();
    send_field(2'b01, 8'hFE, {8'h33, 8'h44}, sts);
    enable = 1'b0;
    idle(1);
    abort_st = st;
    idle(3);
    enable = 1'b1;
    idle(1);
    check("en_abort", {32'(abort_q.size()), 32'(abort_q.size() > 0 ? abort_q[0] : -1)}, {32'd1, 32'(abort_st)});
    check("en_noid", 64'(id_q.size()), 64'd0);

    // Enable low in IDLE after good ID clears id_good, keeps id_*.
    clear_logs();
    send_field(2'b01, 8'hFE, id_body(8'h55, 8'h01, 8'h09, 8'h01, 1'b0), sts);
    enable = 1'b0;
    idle(2);
    enable = 1'b1;
    send_field(2'b10, 8'hFB, rand_payload(4), sts);
    idle(1);
    check("en_idle_orphan", {32'(orph_q.size()), 32'(abort_q.size())}, {32'd1, 32'd0});
    check("en_idle_keep", {32'h0, id_cyl, id_head, id_sector, id_size}, {32'h0, 8'h55, 8'h01, 8'h09, 8'h01});
    check("en_idle_nodata", 64'(db_q.size()), 64'd0);

    // Synchronous reset mid-data field.
    send_field(2'b01, 8'hFE, id_body(8'h01, 8'h00, 8'h02, 8'h00, 1'b0), sts);
    clear_logs();
    send_field(2'b10, 8'hFB, rand_payload(50), sts);
    reset = 1'b1;
    step(1'b1, 8'($urandom), 1'b0, 2'b00);
    check("rst_mid_outputs",
          {2'b0, id_valid, id_cyl, id_head, id_sector, id_size, id_crc_ok, data_byte,
           data_byte_valid, data_index, data_done, data_crc_ok, data_deleted, orphan_dam, field_abort},
          64'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0, 2'($urandom));
    check("rst_mid_quiet", {32'(db_q.size()), 32'(dn_q.size() + abort_q.size() + id_q.size())}, {32'd50, 32'd0});
    send_field(2'b10, 8'hFB, rand_payload(2), sts);
    idle(1);
    check("rst_mid_orphan", 64'(orph_q.size()), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
